fb_span_gen: RTL and testbench
==============================

FB_SPAN_GEN -- requirements
Module: fb_span_gen

Interface
REQ-001 Parameter FB_WIDTH, default 640, pixels per framebuffer row.
REQ-002 Parameter FB_HEIGHT, default 480, rows per framebuffer.
REQ-003 PLB_clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 span_valid  in  1  span command offered.
REQ-006 span_ready  out  1  block accepts a span command this cycle.
REQ-007 span_y  in  [0:9]  row of span.
REQ-008 span_x0  in  [0:9]  first pixel column, inclusive.
REQ-009 span_x1  in  [0:9]  last pixel column, inclusive.
REQ-010 span_color  in  [0:31]  pixel colour.
REQ-011 span_z  in  [0:31]  pixel depth.
REQ-012 fb_base  in  [0:29]  framebuffer word base address; sampled only at span acceptance.
REQ-013 fifo_data  out  [0:95]  pixel entry to the writer FIFO = {addr[0:29], 2'b00, color[0:31], z[0:31]}.
REQ-014 fifo_wr_en  out  1  write strobe to the FIFO; one pixel per asserted cycle.
REQ-015 fifo_full  in  1  FIFO cannot accept a write this cycle.
REQ-016 busy  out  1  high while a span is being emitted.
REQ-017 drop_count  out  [0:7]  number of rejected spans, saturating at 255.

Function
REQ-018 States: IDLE and EMIT only; span_ready SHALL equal (state==IDLE && !reset).
REQ-019 Acceptance: a span SHALL be accepted on a rising edge where span_valid && span_ready.
REQ-020 Rejection: an accepted span with span_y >= FB_HEIGHT, span_x0 > span_x1, or span_x0 >= FB_WIDTH SHALL be dropped, SHALL increment drop_count (saturating), and SHALL leave the state in IDLE.
REQ-021 Clipping: if span_x1 >= FB_WIDTH, the effective last column SHALL be FB_WIDTH-1.
REQ-022 On a valid acceptance, the block SHALL register addr = fb_base + span_y*FB_WIDTH + span_x0 (modulo 2^30), x = span_x0, the effective x1, color and z, and SHALL enter EMIT.
REQ-023 fifo_data SHALL be registered and SHALL present the current pixel from the cycle after acceptance onward.
REQ-024 fifo_wr_en SHALL equal (state==EMIT && !fifo_full), combinationally.
REQ-025 Each cycle in EMIT with fifo_wr_en=1 and x != effective x1: x and addr SHALL increment by 1 on the edge.
REQ-026 Each cycle in EMIT with fifo_wr_en=1 and x == effective x1: the state SHALL return to IDLE on the edge.
REQ-027 Latency: the first fifo_wr_en SHALL occur exactly 1 cycle after acceptance when fifo_full=0.
REQ-028 Throughput: a span of N pixels SHALL take exactly N unstalled EMIT cycles; back-to-back spans SHALL incur exactly one IDLE cycle between them.
REQ-029 Stall: while fifo_full=1 in EMIT, fifo_data, x and addr SHALL hold and no pixel SHALL be lost or duplicated.
REQ-030 Single-pixel spans (x0 == x1) SHALL emit exactly one entry.
REQ-031 Address arithmetic SHALL wrap modulo 2^30 without error indication.
REQ-032 busy SHALL equal (state==EMIT).
REQ-033 span_* inputs SHALL be ignored while not in IDLE.

Reset
REQ-034 reset=1 at a rising edge SHALL force state=IDLE, fifo_data=0, x=0, addr=0, and drop_count=0 regardless of the current state, including mid-span; the remaining pixels of an aborted span SHALL be discarded.
REQ-035 While reset=1, fifo_wr_en=0, span_ready=0 and busy=0.

Verification
REQ-036 Basic span: fb_base=0x1000, y=2, x0=5, x1=8, FIFO never full -> 4 writes, addr 0x1505..0x1508 (0x1000+1280+5 = 0x1505), on cycles 1-4 after acceptance; color and z are copied to every entry.
REQ-037 Backpressure: same span with fifo_full held high on the second write cycle for 3 cycles -> entries unchanged and in order, with no duplicates and busy held high throughout.
REQ-038 Clip and reject: span x0=636, x1=700 -> 4 writes, columns 636-639; then y=480 -> no writes and drop_count=1; then x0=9, x1=3 -> drop_count=2.
REQ-039 Back-to-back: two 1-pixel spans with span_valid held high -> exactly 2 writes, separated by one idle cycle.
REQ-040 Reset mid-span: 10-pixel span with reset asserted after the 3rd write -> fifo_wr_en=0 on the next cycle and the block is IDLE; a new span then emits from its own start address.
REQ-041 Saturation and wrap: 260 rejected spans -> drop_count=255; fb_base=0x3FFFFFFF, y=0, x0=0, x1=1 -> addresses 0x3FFFFFFF then 0x00000000.

Source files
------------

// File: rtl/fb_span_gen.sv
// Horizontal span rasteriser: turns one accepted span command into a stream of
// per-pixel {addr, color, z} entries for the framebuffer writer FIFO.
module fb_span_gen #(
   parameter int unsigned FB_WIDTH  = 640,
   parameter int unsigned FB_HEIGHT = 480
) (
   input  logic        PLB_clk,
   input  logic        reset,
   input  logic        span_valid,
   output logic        span_ready,
   input  logic [0:9]  span_y,
   input  logic [0:9]  span_x0,
   input  logic [0:9]  span_x1,
   input  logic [0:31] span_color,
   input  logic [0:31] span_z,
   input  logic [0:29] fb_base,
   output logic [0:95] fifo_data,
   output logic        fifo_wr_en,
   input  logic        fifo_full,
   output logic        busy,
   output logic [0:7]  drop_count
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [0:29] r_addr;
   logic [0:9]  r_x;
   logic [0:9]  r_x1;
   logic [0:31] r_color;
   logic [0:31] r_z;
   logic [0:7]  r_drop;

   logic        w_accept;
   logic        w_reject;
   logic        w_last;
   logic [0:9]  w_x1_eff;
   logic [0:29] w_addr0;

   assign w_accept = span_valid && span_ready;
   assign w_reject = (32'(span_y) >= FB_HEIGHT) || (span_x0 > span_x1) ||
                     (32'(span_x0) >= FB_WIDTH);
   assign w_x1_eff = (32'(span_x1) >= FB_WIDTH) ? 10'(FB_WIDTH - 1) : span_x1;
   // Row-major word address; truncation to 30 bits gives the required wrap.
   assign w_addr0  = fb_base + 30'(span_y) * 30'(FB_WIDTH) + 30'(span_x0);
   assign w_last   = (r_x == r_x1);

   // Reset gating keeps the handshake outputs quiet even when reset lands mid-span.
   assign span_ready = (r_state == IDLE) && !reset;
   assign fifo_wr_en = (r_state == EMIT) && !fifo_full && !reset;
   assign busy       = (r_state == EMIT) && !reset;
   assign fifo_data  = {r_addr, 2'b00, r_color, r_z};
   assign drop_count = r_drop;

   always_ff @(posedge PLB_clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_reject) w_state_nxt = EMIT;
         end
         EMIT: begin
            if (fifo_wr_en && w_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PLB_clk) begin
      if (reset) begin
         r_addr  <= '0;
         r_x     <= '0;
         r_x1    <= '0;
         r_color <= '0;
         r_z     <= '0;
         r_drop  <= '0;
      end else if (w_accept) begin
         if (w_reject) begin
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end else begin
            r_addr  <= w_addr0;
            r_x     <= span_x0;
            r_x1    <= w_x1_eff;
            r_color <= span_color;
            r_z     <= span_z;
         end
      end else if (fifo_wr_en && !w_last) begin
         // A stalled cycle falls through here untouched, so the entry is held.
         r_x    <= r_x + 10'd1;
         r_addr <= r_addr + 30'd1;
      end
   end

endmodule

// File: tb/tb_fb_span_gen.sv
// Directed bench for fb_span_gen: reset, basic span, backpressure, clip/reject,
// back-to-back, mid-span reset, drop saturation and address wrap.
module tb_fb_span_gen;

   logic        PLB_clk = 1'b0;
   logic        reset = 1'b1;
   logic        span_valid = 1'b0;
   logic        span_ready;
   logic [0:9]  span_y = '0;
   logic [0:9]  span_x0 = '0;
   logic [0:9]  span_x1 = '0;
   logic [0:31] span_color = '0;
   logic [0:31] span_z = '0;
   logic [0:29] fb_base = '0;
   logic [0:95] fifo_data;
   logic        fifo_wr_en;
   logic        fifo_full = 1'b0;
   logic        busy;
   logic [0:7]  drop_count;

   int vectors = 0;
   int miscompares = 0;

   logic        cap_wr   [1:64];
   logic [95:0] cap_data [1:64];
   logic        cap_busy [1:64];

   fb_span_gen #(.FB_WIDTH(640), .FB_HEIGHT(480)) dut (
      .PLB_clk    (PLB_clk),
      .reset      (reset),
      .span_valid (span_valid),
      .span_ready (span_ready),
      .span_y     (span_y),
      .span_x0    (span_x0),
      .span_x1    (span_x1),
      .span_color (span_color),
      .span_z     (span_z),
      .fb_base    (fb_base),
      .fifo_data  (fifo_data),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .busy       (busy),
      .drop_count (drop_count)
   );

   always #5 PLB_clk = ~PLB_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   function automatic logic [95:0] pix(input logic [29:0] a, input logic [31:0] c, input logic [31:0] z);
      return {a, 2'b00, c, z};
   endfunction

   task automatic step();
      @(posedge PLB_clk);
      #1;
   endtask

   task automatic send_span(input logic [9:0] y, input logic [9:0] x0, input logic [9:0] x1,
                            input logic [31:0] c, input logic [31:0] z, input logic [29:0] base);
      span_y = y; span_x0 = x0; span_x1 = x1;
      span_color = c; span_z = z; fb_base = base;
      span_valid = 1'b1;
      step();
      span_valid = 1'b0;
   endtask

   task automatic capture(input int n, input logic [64:0] full_mask);
      for (int c = 1; c <= n; c++) begin
         fifo_full = full_mask[c];
         #1;
         cap_wr[c]   = fifo_wr_en;
         cap_data[c] = fifo_data;
         cap_busy[c] = busy;
         step();
      end
      fifo_full = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      #1;
      vectors++; if (span_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %0b want 0", span_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b want 0", busy); end
      vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr got %0b want 0", fifo_wr_en); end
      vectors++; if (fifo_data !== 96'h0) begin miscompares++; $display("FAIL rst_data got %h want 0", fifo_data); end
      vectors++; if (drop_count !== 8'h0) begin miscompares++; $display("FAIL rst_drop got %0d want 0", drop_count); end
      step();
      reset = 1'b0;
      #1;
      vectors++; if (span_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %0b want 1", span_ready); end
      step();
   endtask

   task automatic test_basic();
      logic exp_wr;
      send_span(10'd2, 10'd5, 10'd8, 32'hCAFEBABE, 32'h12345678, 30'h1000);
      capture(8, '0);
      for (int c = 1; c <= 8; c++) begin
         exp_wr = (c <= 4);
         vectors++;
         if (cap_wr[c] !== exp_wr) begin miscompares++; $display("FAIL basic_wr c=%0d got %0b want %0b", c, cap_wr[c], exp_wr); end
         if (exp_wr) begin
            vectors++;
            if (cap_data[c] !== pix(30'h1504 + 30'(c), 32'hCAFEBABE, 32'h12345678)) begin
               miscompares++; $display("FAIL basic_data c=%0d got %h want %h", c, cap_data[c], pix(30'h1504 + 30'(c), 32'hCAFEBABE, 32'h12345678));
            end
         end
      end
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %0b want 0", busy); end
      step();
   endtask

   task automatic test_backpressure();
      logic exp_wr;
      int k;
      k = 0;
      send_span(10'd2, 10'd5, 10'd8, 32'h0BADF00D, 32'h00C0FFEE, 30'h1000);
      capture(8, 65'h1C);
      for (int c = 1; c <= 8; c++) begin
         exp_wr = (c == 1) || (c >= 5 && c <= 7);
         vectors++;
         if (cap_wr[c] !== exp_wr) begin miscompares++; $display("FAIL bp_wr c=%0d got %0b want %0b", c, cap_wr[c], exp_wr); end
         if (c <= 7) begin
            vectors++;
            if (cap_data[c] !== pix(30'h1505 + 30'(k), 32'h0BADF00D, 32'h00C0FFEE)) begin
               miscompares++; $display("FAIL bp_data c=%0d got %h want %h", c, cap_data[c], pix(30'h1505 + 30'(k), 32'h0BADF00D, 32'h00C0FFEE));
            end
            vectors++;
            if (cap_busy[c] !== 1'b1) begin miscompares++; $display("FAIL bp_busy c=%0d got %0b want 1", c, cap_busy[c]); end
         end else begin
            vectors++;
            if (cap_busy[c] !== 1'b0) begin miscompares++; $display("FAIL bp_busy_end c=%0d got %0b want 0", c, cap_busy[c]); end
         end
         if (exp_wr) k++;
      end
   endtask

   task automatic test_clip_reject();
      logic exp_wr;
      send_span(10'd1, 10'd636, 10'd700, 32'h11111111, 32'h22222222, 30'h0);
      capture(6, '0);
      for (int c = 1; c <= 6; c++) begin
         exp_wr = (c <= 4);
         vectors++;
         if (cap_wr[c] !== exp_wr) begin miscompares++; $display("FAIL clip_wr c=%0d got %0b want %0b", c, cap_wr[c], exp_wr); end
         if (exp_wr) begin
            vectors++;
            if (cap_data[c] !== pix(30'd1275 + 30'(c), 32'h11111111, 32'h22222222)) begin
               miscompares++; $display("FAIL clip_data c=%0d got %h want %h", c, cap_data[c], pix(30'd1275 + 30'(c), 32'h11111111, 32'h22222222));
            end
         end
      end
      send_span(10'd480, 10'd0, 10'd1, 32'h1, 32'h2, 30'h0);
      capture(3, '0);
      for (int c = 1; c <= 3; c++) begin
         vectors++;
         if (cap_wr[c] !== 1'b0) begin miscompares++; $display("FAIL rej_y_wr c=%0d got %0b want 0", c, cap_wr[c]); end
      end
      #1;
      vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL rej_y_drop got %0d want 1", drop_count); end
      send_span(10'd0, 10'd9, 10'd3, 32'h1, 32'h2, 30'h0);
      #1;
      vectors++; if (drop_count !== 8'd2) begin miscompares++; $display("FAIL rej_order_drop got %0d want 2", drop_count); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rej_busy got %0b want 0", busy); end
      send_span(10'd0, 10'd640, 10'd645, 32'h1, 32'h2, 30'h0);
      #1;
      vectors++; if (drop_count !== 8'd3) begin miscompares++; $display("FAIL rej_x0_drop got %0d want 3", drop_count); end
      vectors++; if (span_ready !== 1'b1) begin miscompares++; $display("FAIL rej_ready got %0b want 1", span_ready); end
      step();
   endtask

   task automatic test_back_to_back();
      logic exp_wr;
      for (int c = 0; c <= 5; c++) begin
         if (c == 0) begin
            span_y = 10'd3; span_x0 = 10'd10; span_x1 = 10'd10;
            span_color = 32'hAAAA0001; span_z = 32'hA0A0A0A0; fb_base = 30'h0;
            span_valid = 1'b1;
         end
         if (c == 1) begin
            span_y = 10'd4; span_x0 = 10'd20; span_x1 = 10'd20;
            span_color = 32'hBBBB0002; span_z = 32'hB0B0B0B0;
         end
         if (c == 3) span_valid = 1'b0;
         #1;
         exp_wr = (c == 1) || (c == 3);
         vectors++;
         if (fifo_wr_en !== exp_wr) begin miscompares++; $display("FAIL b2b_wr c=%0d got %0b want %0b", c, fifo_wr_en, exp_wr); end
         if (c == 1) begin
            vectors++;
            if (fifo_data !== pix(30'd1930, 32'hAAAA0001, 32'hA0A0A0A0)) begin
               miscompares++; $display("FAIL b2b_data_a got %h want %h", fifo_data, pix(30'd1930, 32'hAAAA0001, 32'hA0A0A0A0));
            end
         end
         if (c == 2) begin
            vectors++;
            if (span_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_gap_ready got %0b want 1", span_ready); end
         end
         if (c == 3) begin
            vectors++;
            if (fifo_data !== pix(30'd2580, 32'hBBBB0002, 32'hB0B0B0B0)) begin
               miscompares++; $display("FAIL b2b_data_b got %h want %h", fifo_data, pix(30'd2580, 32'hBBBB0002, 32'hB0B0B0B0));
            end
         end
         step();
      end
   endtask

   task automatic test_reset_mid_span();
      send_span(10'd0, 10'd0, 10'd9, 32'hDEADBEEF, 32'h55AA55AA, 30'h200);
      for (int c = 1; c <= 3; c++) begin
         #1;
         vectors++;
         if (fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_wr c=%0d got %0b want 1", c, fifo_wr_en); end
         vectors++;
         if (fifo_data !== pix(30'h1FF + 30'(c), 32'hDEADBEEF, 32'h55AA55AA)) begin
            miscompares++; $display("FAIL mid_data c=%0d got %h want %h", c, fifo_data, pix(30'h1FF + 30'(c), 32'hDEADBEEF, 32'h55AA55AA));
         end
         step();
      end
      reset = 1'b1;
      #1;
      vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wr got %0b want 0", fifo_wr_en); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %0b want 0", busy); end
      vectors++; if (span_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %0b want 0", span_ready); end
      step();
      reset = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got %0b want 0", busy); end
      vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL post_rst_wr got %0b want 0", fifo_wr_en); end
      vectors++; if (fifo_data !== 96'h0) begin miscompares++; $display("FAIL post_rst_data got %h want 0", fifo_data); end
      vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL post_rst_drop got %0d want 0", drop_count); end
      vectors++; if (span_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %0b want 1", span_ready); end
      send_span(10'd1, 10'd2, 10'd3, 32'h01020304, 32'h05060708, 30'h0);
      capture(4, '0);
      for (int c = 1; c <= 4; c++) begin
         vectors++;
         if (cap_wr[c] !== (c <= 2)) begin miscompares++; $display("FAIL new_wr c=%0d got %0b want %0b", c, cap_wr[c], (c <= 2)); end
         if (c <= 2) begin
            vectors++;
            if (cap_data[c] !== pix(30'd641 + 30'(c), 32'h01020304, 32'h05060708)) begin
               miscompares++; $display("FAIL new_data c=%0d got %h want %h", c, cap_data[c], pix(30'd641 + 30'(c), 32'h01020304, 32'h05060708));
            end
         end
      end
   endtask

   task automatic test_saturation();
      span_y = 10'd480; span_x0 = 10'd0; span_x1 = 10'd0;
      span_valid = 1'b1;
      repeat (254) step();
      vectors++; if (drop_count !== 8'd254) begin miscompares++; $display("FAIL sat_254 got %0d want 254", drop_count); end
      repeat (6) step();
      span_valid = 1'b0;
      vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL sat_255 got %0d want 255", drop_count); end
      step();
   endtask

   task automatic test_wrap();
      send_span(10'd0, 10'd0, 10'd1, 32'h77777777, 32'h88888888, 30'h3FFFFFFF);
      capture(4, '0);
      vectors++; if (cap_wr[1] !== 1'b1) begin miscompares++; $display("FAIL wrap_wr1 got %0b want 1", cap_wr[1]); end
      vectors++;
      if (cap_data[1] !== pix(30'h3FFFFFFF, 32'h77777777, 32'h88888888)) begin
         miscompares++; $display("FAIL wrap_data1 got %h want %h", cap_data[1], pix(30'h3FFFFFFF, 32'h77777777, 32'h88888888));
      end
      vectors++; if (cap_wr[2] !== 1'b1) begin miscompares++; $display("FAIL wrap_wr2 got %0b want 1", cap_wr[2]); end
      vectors++;
      if (cap_data[2] !== pix(30'h0, 32'h77777777, 32'h88888888)) begin
         miscompares++; $display("FAIL wrap_data2 got %h want %h", cap_data[2], pix(30'h0, 32'h77777777, 32'h88888888));
      end
      vectors++; if (cap_wr[3] !== 1'b0) begin miscompares++; $display("FAIL wrap_wr3 got %0b want 0", cap_wr[3]); end
      #1;
      vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL wrap_drop got %0d want 255", drop_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_clip_reject();
      test_back_to_back();
      test_reset_mid_span();
      test_saturation();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
